// File: rtl/id_stage_hz_if.sv
// IF/ID/EX-facing signal bundle for the decode stage.
// master: the IF/EX/debug side that drives instructions and control.
// slave:  the decode stage itself.
interface id_stage_hz_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] next_pc;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            redirect;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic            out_valid;
  logic            ex_op, alu_src, reg_dst, mem_wr, branch, branch_ne;
  logic            jreturn, jump, jcall, mem2reg, reg_wr;
  logic [3:0]      alu_op;
  logic            illegal;
  logic [XLEN-1:0] next_pc_id;
  logic [XLEN-1:0] bus_a, bus_b;
  logic [15:0]     imm;
  logic [4:0]      rs, rt, rd;
  logic            wb_we_d;
  logic [4:0]      wb_addr_d;
  logic [XLEN-1:0] wb_data_d;

  modport master (
    output in_valid, instr, next_pc, wb_we, wb_addr, wb_data, flush, redirect, dbg_addr,
    input  in_ready, dbg_data, out_valid, ex_op, alu_src, reg_dst, mem_wr, branch, branch_ne,
    input  jreturn, jump, jcall, mem2reg, reg_wr, alu_op, illegal, next_pc_id, bus_a, bus_b,
    input  imm, rs, rt, rd, wb_we_d, wb_addr_d, wb_data_d
  );

  modport slave (
    input  in_valid, instr, next_pc, wb_we, wb_addr, wb_data, flush, redirect, dbg_addr,
    output in_ready, dbg_data, out_valid, ex_op, alu_src, reg_dst, mem_wr, branch, branch_ne,
    output jreturn, jump, jcall, mem2reg, reg_wr, alu_op, illegal, next_pc_id, bus_a, bus_b,
    output imm, rs, rt, rd, wb_we_d, wb_addr_d, wb_data_d
  );
endinterface

// File: rtl/id_stage_hz.sv
// Decode stage: instruction decode, 32-entry register file with write-first
// bypass, load-use stall, flush, post-redirect squash, and ID/EX register.
module id_stage_hz #(
  parameter int XLEN          = 32,
  parameter int SQUASH_DEPTH  = 3,
  parameter int LOADUSE_STALL = 1
) (
  input logic          clk,
  input logic          rst_n,
  id_stage_hz_if.slave bus
);

  typedef struct packed {
    logic       ex_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_wr;
    logic       branch;
    logic       branch_ne;
    logic       jreturn;
    logic       jump;
    logic       jcall;
    logic       mem2reg;
    logic       reg_wr;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_DEPTH);

  logic [XLEN-1:0] rf_q [32];

  logic [5:0] op, func;
  logic [4:0] rs_f, rt_dec;
  logic       uses_rt, hazard, take, load;
  ctrl_t      ctrl_dec, ctrl_d, ctrl_q;
  logic [2:0] sq_d, sq_q;

  logic            out_valid_q;
  logic [XLEN-1:0] next_pc_q, bus_a_q, bus_b_q;
  logic [15:0]     imm_q;
  logic [4:0]      rs_q, rt_q, rd_q;
  logic            wb_we_dly_q;
  logic [4:0]      wb_addr_dly_q;
  logic [XLEN-1:0] wb_data_dly_q;

  assign op   = bus.instr[31:26];
  assign func = bus.instr[5:0];
  assign rs_f = bus.instr[25:21];

  // Combinational read; a same-cycle write to the addressed register wins.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
    if (a == 5'd0)
      return '0;
    if (bus.wb_we && bus.wb_addr == a)
      return bus.wb_data;
    return rf_q[a];
  endfunction

  // Register file storage; r0 is never written so it stays 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Instruction decode into the control bundle.
  always_comb begin
    ctrl_dec = '0;
    rt_dec   = bus.instr[20:16];
    if (op == 6'd0) begin
      if (func == 6'b001011) begin
        ctrl_dec.jreturn = 1'b1;
      end else if (func != 6'd0) begin
        ctrl_dec.alu_op  = func[4] ? {1'b1, func[2:0]} : func[3:0];
        ctrl_dec.reg_dst = 1'b1;
        ctrl_dec.reg_wr  = 1'b1;
      end
    end else if (!op[5]) begin
      ctrl_dec.ex_op = ~op[4];
      case (op)
        6'b001110: begin
          ctrl_dec.alu_op  = 4'b1001;
          ctrl_dec.alu_src = 1'b1;
          ctrl_dec.mem2reg = 1'b1;
          ctrl_dec.reg_wr  = 1'b1;
        end
        6'b001111: begin
          ctrl_dec.alu_op  = 4'b1001;
          ctrl_dec.alu_src = 1'b1;
          ctrl_dec.mem_wr  = 1'b1;
        end
        6'b001000: begin
          ctrl_dec.alu_op = 4'b1010;
          ctrl_dec.branch = 1'b1;
        end
        6'b001001: begin
          ctrl_dec.alu_op    = 4'b1010;
          ctrl_dec.branch_ne = 1'b1;
        end
        default: begin
          ctrl_dec.alu_src = 1'b1;
          ctrl_dec.reg_wr  = 1'b1;
          ctrl_dec.alu_op  = op[4] ? {1'b1, op[2:0]} : op[3:0];
        end
      endcase
    end else if (op == 6'b100000) begin
      ctrl_dec.jump = 1'b1;
    end else if (op == 6'b100001) begin
      ctrl_dec.jcall  = 1'b1;
      ctrl_dec.reg_wr = 1'b1;
      rt_dec          = 5'd31;
    end else begin
      ctrl_dec.illegal = 1'b1;
    end
  end

  // Load-use detection against the load sitting in ID/EX; flush always consumes.
  always_comb begin
    uses_rt = (op == 6'd0) || (op == 6'b001111) || (op == 6'b001000) || (op == 6'b001001);
    hazard  = (LOADUSE_STALL != 0) && out_valid_q && ctrl_q.mem2reg && ctrl_q.reg_wr &&
              (rt_q != 5'd0) &&
              ((rt_q == rs_f) || (uses_rt && rt_q == bus.instr[20:16]));
    take    = bus.in_valid && (bus.flush || !hazard);
    load    = take && !bus.flush;
    ctrl_d  = '0;
    if (load) begin
      ctrl_d = ctrl_dec;
      if (sq_q != 3'd0) begin
        ctrl_d.reg_wr = 1'b0;
        ctrl_d.mem_wr = 1'b0;
      end
    end
  end

  // Squash counter: redirect reloads, each consumed instruction counts down.
  always_comb begin
    sq_d = sq_q;
    if (bus.redirect)
      sq_d = SQ_LOAD;
    else if (take && sq_q != 3'd0)
      sq_d = sq_q - 3'd1;
  end

  // ID/EX register, squash counter and write-back delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      ctrl_q        <= '0;
      sq_q          <= 3'd0;
      next_pc_q     <= '0;
      bus_a_q       <= '0;
      bus_b_q       <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      wb_we_dly_q   <= 1'b0;
      wb_addr_dly_q <= '0;
      wb_data_dly_q <= '0;
    end else begin
      out_valid_q   <= load;
      ctrl_q        <= ctrl_d;
      sq_q          <= sq_d;
      next_pc_q     <= bus.next_pc;
      bus_a_q       <= rf_read(rs_f);
      bus_b_q       <= rf_read(rt_dec);
      imm_q         <= bus.instr[15:0];
      rs_q          <= rs_f;
      rt_q          <= rt_dec;
      rd_q          <= bus.instr[15:11];
      wb_we_dly_q   <= bus.wb_we;
      wb_addr_dly_q <= bus.wb_addr;
      wb_data_dly_q <= bus.wb_data;
    end
  end

  assign bus.in_ready   = bus.flush || !hazard;
  assign bus.dbg_data   = rf_read(bus.dbg_addr);
  assign bus.out_valid  = out_valid_q;
  assign bus.ex_op      = ctrl_q.ex_op;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_wr     = ctrl_q.mem_wr;
  assign bus.branch     = ctrl_q.branch;
  assign bus.branch_ne  = ctrl_q.branch_ne;
  assign bus.jreturn    = ctrl_q.jreturn;
  assign bus.jump       = ctrl_q.jump;
  assign bus.jcall      = ctrl_q.jcall;
  assign bus.mem2reg    = ctrl_q.mem2reg;
  assign bus.reg_wr     = ctrl_q.reg_wr;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.illegal    = ctrl_q.illegal;
  assign bus.next_pc_id = next_pc_q;
  assign bus.bus_a      = bus_a_q;
  assign bus.bus_b      = bus_b_q;
  assign bus.imm        = imm_q;
  assign bus.rs         = rs_q;
  assign bus.rt         = rt_q;
  assign bus.rd         = rd_q;
  assign bus.wb_we_d    = wb_we_dly_q;
  assign bus.wb_addr_d  = wb_addr_dly_q;
  assign bus.wb_data_d  = wb_data_dly_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: stimulus pushes expected ID/EX bundles,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_id_stage_hz;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_hz_if #(.XLEN(XLEN)) bus ();
  id_stage_hz_if #(.XLEN(XLEN)) nbus ();

  id_stage_hz #(.XLEN(XLEN), .SQUASH_DEPTH(3), .LOADUSE_STALL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  id_stage_hz #(.XLEN(XLEN), .SQUASH_DEPTH(3), .LOADUSE_STALL(0)) u_nst (
    .clk(clk), .rst_n(rst_n), .bus(nbus.slave));

  typedef struct {
    logic [63:0] tag;
    logic [15:0] ctrl;
    logic [4:0]  rt;
    bit          chk_a;
    logic [31:0] a;
    logic [31:0] npc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] func);
    return {6'd0, rs, rt, rd, 5'd0, func};
  endfunction

  // Expected bundle order: ex_op alu_src reg_dst mem_wr branch branch_ne jreturn jump jcall mem2reg reg_wr alu_op illegal
  function automatic logic [15:0] cb(input bit ex, input bit src, input bit dst, input bit mw,
                                     input bit br, input bit bn, input bit jr, input bit j,
                                     input bit jc, input bit m2r, input bit rw,
                                     input logic [3:0] aop, input bit ill);
    return {ex, src, dst, mw, br, bn, jr, j, jc, m2r, rw, aop, ill};
  endfunction

  function automatic logic [15:0] ctrl_now();
    return {bus.ex_op, bus.alu_src, bus.reg_dst, bus.mem_wr, bus.branch, bus.branch_ne,
            bus.jreturn, bus.jump, bus.jcall, bus.mem2reg, bus.reg_wr, bus.alu_op, bus.illegal};
  endfunction

  task automatic cmp(input logic [63:0] tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_bubble(input logic [63:0] tag);
    checks++;
    if (bus.out_valid !== 1'b0 || ctrl_now() !== 16'h0000) begin
      errors++;
      $display("FAIL %s: out_valid=%b ctrl=%h expected out_valid=0 ctrl=0000",
               tag, bus.out_valid, ctrl_now());
    end
  endtask

  // One instruction presented for one cycle; called at posedge+1, returns at posedge+1.
  task automatic issue(input logic [63:0] tag, input logic [31:0] ins, input logic fl,
                       input logic rd, input logic exp_rdy, input logic [15:0] ectrl,
                       input logic [4:0] ert, input bit ca, input logic [31:0] ea);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.flush    = fl;
    bus.redirect = rd;
    bus.next_pc  = bus.next_pc + 32'd4;
    #2;
    cmp({tag[55:0], "R"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    if (exp_rdy && !fl) begin
      e.tag = tag; e.ctrl = ectrl; e.rt = ert; e.chk_a = ca; e.a = ea; e.npc = bus.next_pc;
      sbq.push_back(e);
    end
    $display("txn %s instr=%h flush=%b redirect=%b ready=%b", tag, ins, fl, rd, bus.in_ready);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.redirect = 1'b0;
  endtask

  task automatic redir_idle();
    bus.redirect = 1'b1;
    bus.in_valid = 1'b0;
    $display("txn redirect (idle)");
    @(posedge clk); #1;
    bus.redirect = 1'b0;
  endtask

  // Monitor: every real instruction leaving ID/EX is matched against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 with no expected entry, ctrl=%h", ctrl_now());
      end else begin
        e = sbq.pop_front();
        checks++;
        if (ctrl_now() !== e.ctrl) begin
          errors++;
          $display("FAIL %s ctrl: got %h expected %h", e.tag, ctrl_now(), e.ctrl);
        end
        checks++;
        if (bus.rt !== e.rt) begin
          errors++;
          $display("FAIL %s rt: got %0d expected %0d", e.tag, bus.rt, e.rt);
        end
        checks++;
        if (bus.next_pc_id !== e.npc) begin
          errors++;
          $display("FAIL %s next_pc_id: got %h expected %h", e.tag, bus.next_pc_id, e.npc);
        end
        if (e.chk_a) begin
          checks++;
          if (bus.bus_a !== e.a) begin
            errors++;
            $display("FAIL %s bus_a: got %h expected %h", e.tag, bus.bus_a, e.a);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] i_lw, i_add, i_addi3, i_sw, i_addi, i_sub, i_ori;
    logic [15:0] c_lw, c_add, c_addi, c_addi_sq, c_sw, c_sw_sq;
    i_lw    = enc_i(6'b001110, 5'd1, 5'd3, 16'h0000);
    i_add   = enc_r(5'd3, 5'd2, 5'd4, 6'b100000);
    i_addi3 = enc_i(6'b010001, 5'd1, 5'd3, 16'h0005);
    i_sw    = enc_i(6'b001111, 5'd1, 5'd3, 16'h0004);
    i_addi  = enc_i(6'b010001, 5'd5, 5'd9, 16'h0001);
    i_sub   = enc_r(5'd5, 5'd6, 5'd7, 6'b010110);
    i_ori   = enc_i(6'b000101, 5'd2, 5'd8, 16'h0001);
    c_lw      = cb(1,1,0,0,0,0,0,0,0,1,1,4'b1001,0);
    c_add     = cb(0,0,1,0,0,0,0,0,0,0,1,4'b0000,0);
    c_addi    = cb(0,1,0,0,0,0,0,0,0,0,1,4'b1001,0);
    c_addi_sq = cb(0,1,0,0,0,0,0,0,0,0,0,4'b1001,0);
    c_sw      = cb(1,1,0,1,0,0,0,0,0,0,0,4'b1001,0);
    c_sw_sq   = cb(1,1,0,0,0,0,0,0,0,0,0,4'b1001,0);

    // Defaults; a write is held during reset to prove reset wins.
    rst_n = 1'b0;
    bus.in_valid = 0; bus.instr = 0; bus.next_pc = 32'h1000; bus.flush = 0; bus.redirect = 0;
    bus.wb_we = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'hDEAD; bus.dbg_addr = 0;
    nbus.in_valid = 0; nbus.instr = 0; nbus.next_pc = 32'h2000; nbus.flush = 0; nbus.redirect = 0;
    nbus.wb_we = 0; nbus.wb_addr = 0; nbus.wb_data = 0; nbus.dbg_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_bubble("rst_ctrl");
    cmp("rst_npc", bus.next_pc_id, 32'h0);
    cmp("rst_wbwe", {31'd0, bus.wb_we_d}, 32'h0);
    cmp("rst_wbdt", bus.wb_data_d, 32'h0);
    bus.wb_we = 0; bus.dbg_addr = 5'd7;
    #1;
    cmp("rst_r7", bus.dbg_data, 32'h0);

    // Register file: write-first bypass, r0 hardwired, write-back delay.
    @(posedge clk); #1;
    bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234; bus.dbg_addr = 5'd5;
    #2;
    cmp("byp_r5", bus.dbg_data, 32'h1234);
    @(posedge clk); #1;
    cmp("wbd_we", {31'd0, bus.wb_we_d}, 32'h1);
    cmp("wbd_adr", {27'd0, bus.wb_addr_d}, 32'd5);
    cmp("wbd_dat", bus.wb_data_d, 32'h1234);
    bus.wb_we = 0;
    #1;
    cmp("hold_r5", bus.dbg_data, 32'h1234);
    bus.wb_we = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF; bus.dbg_addr = 5'd0;
    #1;
    cmp("byp_r0", bus.dbg_data, 32'h0);
    @(posedge clk); #1;
    bus.wb_addr = 5'd1; bus.wb_data = 32'h100;
    #1;
    cmp("hold_r0", rf_r0_probe(), 32'h0);
    @(posedge clk); #1;
    bus.wb_addr = 5'd2; bus.wb_data = 32'h22;
    @(posedge clk); #1;
    bus.wb_we = 0;

    // LOADUSE_STALL=0 instance: the dependent add goes straight through.
    nbus.in_valid = 1; nbus.instr = i_lw;
    @(posedge clk); #1;
    nbus.instr = i_add;
    #2;
    cmp("nst_rdy", {31'd0, nbus.in_ready}, 32'h1);
    $display("txn nostall lw->add ready=%b", nbus.in_ready);
    @(posedge clk); #1;
    nbus.in_valid = 0;
    cmp("nst_ov", {31'd0, nbus.out_valid}, 32'h1);
    cmp("nst_dst", {31'd0, nbus.reg_dst}, 32'h1);

    // Load-use: one-cycle stall with bubble, then the add is taken.
    issue("lw",     i_lw,  0, 0, 1, c_lw,  5'd3, 1, 32'h100);
    issue("add_stl", i_add, 0, 0, 0, 16'h0, 5'd0, 0, 32'h0);
    chk_bubble("stl_bub");
    issue("add",    i_add, 0, 0, 1, c_add, 5'd2, 1, 32'h0);
    // I-type whose rt matches the load dest is not a consumer of rt.
    issue("lw2",    i_lw,    0, 0, 1, c_lw,   5'd3, 0, 32'h0);
    issue("addi_rt", i_addi3, 0, 0, 1, c_addi, 5'd3, 1, 32'h100);
    // sw reads rt, so it stalls.
    issue("lw3",    i_lw, 0, 0, 1, c_lw, 5'd3, 0, 32'h0);
    issue("sw_stl", i_sw, 0, 0, 0, 16'h0, 5'd0, 0, 32'h0);
    chk_bubble("sw_bub");
    issue("sw",     i_sw, 0, 0, 1, c_sw, 5'd3, 0, 32'h0);

    // Flush during a hazard cycle: consumed, bubble loaded.
    issue("lw4",    i_lw,  0, 0, 1, c_lw, 5'd3, 0, 32'h0);
    issue("add_fl", i_add, 1, 0, 1, 16'h0, 5'd0, 0, 32'h0);
    chk_bubble("fl_bub");
    issue("add2",   i_add, 0, 0, 1, c_add, 5'd2, 0, 32'h0);

    // Decode table.
    issue("jal",  {6'b100001, 26'h0000123}, 0, 0, 1, cb(0,0,0,0,0,0,0,0,1,0,1,4'b0000,0), 5'd31, 0, 0);
    issue("ill",  {6'b110000, 5'd1, 5'd2, 16'h0}, 0, 0, 1, cb(0,0,0,0,0,0,0,0,0,0,0,4'b0000,1), 5'd2, 0, 0);
    issue("nop",  32'h0, 0, 0, 1, 16'h0, 5'd0, 0, 0);
    issue("sub",  i_sub, 0, 0, 1, cb(0,0,1,0,0,0,0,0,0,0,1,4'b1110,0), 5'd6, 1, 32'h1234);
    issue("beq",  enc_i(6'b001000, 5'd1, 5'd2, 16'h8), 0, 0, 1, cb(1,0,0,0,1,0,0,0,0,0,0,4'b1010,0), 5'd2, 0, 0);
    issue("bne",  enc_i(6'b001001, 5'd1, 5'd2, 16'h8), 0, 0, 1, cb(1,0,0,0,0,1,0,0,0,0,0,4'b1010,0), 5'd2, 0, 0);
    issue("jr",   enc_r(5'd31, 5'd0, 5'd0, 6'b001011), 0, 0, 1, cb(0,0,0,0,0,0,1,0,0,0,0,4'b0000,0), 5'd0, 0, 0);
    issue("j",    {6'b100000, 26'h10}, 0, 0, 1, cb(0,0,0,0,0,0,0,1,0,0,0,4'b0000,0), 5'd0, 0, 0);
    issue("ori",  i_ori, 0, 0, 1, cb(1,1,0,0,0,0,0,0,0,0,1,4'b0101,0), 5'd8, 1, 32'h22);

    // Squash: 3 instructions after a redirect lose reg_wr/mem_wr.
    redir_idle();
    issue("sq1", i_addi, 0, 0, 1, c_addi_sq, 5'd9, 0, 0);
    issue("sq2", i_addi, 0, 0, 1, c_addi_sq, 5'd9, 0, 0);
    issue("sq3", i_addi, 0, 0, 1, c_addi_sq, 5'd9, 0, 0);
    issue("sq4", i_addi, 0, 0, 1, c_addi,    5'd9, 0, 0);
    // Redirect on the 2nd instruction reloads the counter.
    redir_idle();
    issue("rl1", i_addi, 0, 0, 1, c_addi_sq, 5'd9, 0, 0);
    issue("rl2", i_addi, 0, 1, 1, c_addi_sq, 5'd9, 0, 0);
    issue("rl3", i_sw,   0, 0, 1, c_sw_sq,   5'd3, 0, 0);
    issue("rl4", i_addi, 0, 0, 1, c_addi_sq, 5'd9, 0, 0);
    issue("rl5", i_addi, 0, 0, 1, c_addi_sq, 5'd9, 0, 0);
    issue("rl6", i_addi, 0, 0, 1, c_addi,    5'd9, 0, 0);

    // Mid-stream reset with a pending squash window and a valid instruction.
    redir_idle();
    rst_n = 1'b0;
    bus.in_valid = 1; bus.instr = i_addi; bus.dbg_addr = 5'd5;
    $display("txn reset with in_valid=1");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 0;
    chk_bubble("mrst_bub");
    cmp("mrst_npc", bus.next_pc_id, 32'h0);
    cmp("mrst_r5", bus.dbg_data, 32'h0);
    issue("post_rst", i_addi, 0, 0, 1, c_addi, 5'd9, 1, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    cmp("sb_drain", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Reads r0 through the debug port with no write aimed at it this cycle.
  function automatic logic [31:0] rf_r0_probe();
    return (bus.dbg_addr == 5'd0) ? bus.dbg_data : 32'hBAD0_BAD0;
  endfunction

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised successor to the pipeline decode stage: decodes one 32-bit instruction per cycle, reads and writes the internal 32-entry register file, and registers the ID/EX bundle.
- New relative to the previous generation:
  - Configurable datapath width.
  - Valid/ready handshake toward IF.
  - Internal load-use hazard stall with bubble insertion.
  - Flush input.
  - Squash counter of configurable depth that replaces the fixed external "recent jump" input.
  - Write-first register-file bypass.
  - Defined (non-x) values on every control output.
- Sits between IF and EX; EX drives flush/redirect.

Parameters:
XLEN, 32, datapath/register width (>=16)
SQUASH_DEPTH, 3, accepted instructions after a redirect whose reg_wr/mem_wr are forced 0 (0..7; 0 disables)
LOADUSE_STALL, 1, 1 enables load-use stall detection; 0 never stalls

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  IF presents instr/next_pc
in_ready  out  1  ID accepts this cycle (combinational)
instr  in  32  instruction
next_pc  in  XLEN  PC+4 of instr
wb_we  in  1  write-back enable
wb_addr  in  5  write-back register
wb_data  in  XLEN  write-back data
flush  in  1  kill the instruction currently in ID
redirect  in  1  taken control transfer resolved in EX
dbg_addr  in  5  debug register read address
dbg_data  out  XLEN  debug read data (combinational)
out_valid  out  1  ID/EX holds a real instruction
ex_op, alu_src, reg_dst, mem_wr, branch, branch_ne, jreturn, jump, jcall, mem2reg, reg_wr  out  1 each  control bundle
alu_op  out  4  ALU control
illegal  out  1  undefined opcode decoded
next_pc_id  out  XLEN  registered next_pc
bus_a, bus_b  out  XLEN  rs/rt read data
imm  out  16  instr[15:0]
rs, rt, rd  out  5  register fields (rt=31 for jal)
wb_we_d, wb_addr_d, wb_data_d  out  1/5/XLEN  write-back port delayed one cycle

Behaviour:

Reset:
- rst_n=0 at a clock edge: every registered output goes to 0, the squash counter goes to 0, and all registers r0..r31 go to 0.
- Reset has priority over all other inputs.

Register file:
- Writes on the clock edge when wb_we=1 and wb_addr!=0; r0 always reads 0.
- Reads are combinational.
- A read of wb_addr in the same cycle as its write returns wb_data (write-first bypass), including the dbg port.

Decode (op=instr[31:26], func=instr[5:0]):
- op=0 (R-type), by func:
  - func=0: nop, reg_wr=0.
  - func=001011: jr, jreturn=1.
  - func[4]=1: alu_op={1,func[2:0]}.
  - otherwise: alu_op=func[3:0].
  - Non-nop/non-jr R-type: reg_dst=1, reg_wr=1.
- op[5]=0 (I-type):
  - ex_op=~op[4]; rt=instr[20:16].
  - 001110 lw: alu_op=1001, alu_src=1, mem2reg=1, reg_wr=1.
  - 001111 sw: alu_op=1001, alu_src=1, mem_wr=1.
  - 001000 beq: alu_op=1010, branch=1.
  - 001001 bne: alu_op=1010, branch_ne=1.
  - Other I-type: alu_src=1, reg_wr=1; alu_op={1,op[2:0]} if op[4]=1, else op[3:0].
- op=100000 j: jump=1.
- op=100001 jal: jcall=1, reg_wr=1, rt=31, alu_op=0.
- Any other op[5]=1: illegal=1, all other control bits 0.
- Every control bit not listed above is 0.

Handshake:
- An instruction is accepted when in_valid & in_ready.
- On an accepted edge, ID/EX loads the decoded bundle and out_valid=1.
- Otherwise ID/EX loads a bubble: all control bits 0, illegal=0, out_valid=0.
- Data fields (bus_a, bus_b, imm, rs, rt, rd, next_pc_id) are captured every cycle regardless.

Load-use hazard (LOADUSE_STALL=1):
- hazard is asserted when all of the following hold:
  - out_valid, mem2reg and reg_wr are all 1;
  - rt!=0;
  - rt equals instr[25:21], or rt equals instr[20:16] for an R-type, sw, beq or bne instruction.
- in_ready = ~hazard.
- The bubble inserted by the stall clears the hazard, so the next cycle accepts the instruction: exactly a 1-cycle stall.

Flush:
- flush=1: in_ready=1 (the instruction is consumed), ID/EX loads a bubble.
- flush overrides hazard.

Squash counter (3 bits):
- redirect=1 loads SQUASH_DEPTH; this takes priority over a decrement in the same cycle.
- Else, on accept with counter>0: counter decrements.
- An instruction accepted while counter>0 has reg_wr=0 and mem_wr=0; all other bits are decoded normally.
- A redirect arriving while counter>0 reloads the counter.

Write-back delay:
- wb_we_d, wb_addr_d and wb_data_d register wb_we, wb_addr and wb_data every cycle (forwarding source for EX).

Test Plan:
1. Reset, then write r5=0x1234 and read the same cycle via dbg_addr=5 -> dbg_data=0x1234 same cycle; a write to r0 -> r0 still reads 0.
2. lw r3,0(r1) followed by add r4,r3,r2 with in_valid=1 -> cycle 2: in_ready=0, bubble (out_valid=0); cycle 3: add accepted with alu_op=func[3:0], reg_dst=1, reg_wr=1. Repeat with LOADUSE_STALL=0 -> no stall.
3. redirect pulse with SQUASH_DEPTH=3, then 4 accepted addi instructions -> reg_wr=0 on the first 3, reg_wr=1 on the 4th. A redirect on the 2nd instruction reloads the counter, so the next 3 instructions are squashed.
4. flush during a hazard cycle -> in_ready=1, out_valid=0 next edge, all control bits 0.
5. jal -> rt=31, jcall=1, reg_wr=1. op=110000 -> illegal=1, all other control bits 0. op=0/func=0 -> out_valid=1, reg_wr=0.
6. Reset asserted mid-stream with in_valid=1 -> next edge: out_valid=0, all outputs 0, counter 0, registers read 0.
